// File: rtl/prf_pkg.sv
// prf_pkg: shared register-file defaults (NUM_PREGS/DATA_W/IDX_W) and a clog2 helper for the RS, ROB, free list and PRF
package prf_pkg;
  localparam int PRF_NUM_PREGS = 96;
  localparam int PRF_DATA_W = 64;
  localparam int PRF_IDX_W = 7;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/prf_wr_merge.sv
// prf_wr_merge: next-state merge for one entry (IDX); inputs cur_data/cur_ready + write/alloc buses, outputs next_data/next_ready/hit_dup/hit_alloc
module prf_wr_merge
  import prf_pkg::*;
#(
  parameter int IDX = 0,
  parameter int NUM_WR = 6,
  parameter int NUM_ALLOC = 2,
  parameter int DATA_W = PRF_DATA_W,
  parameter int IDX_W = PRF_IDX_W
) (
  input  logic [DATA_W-1:0]           cur_data,
  input  logic                        cur_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
  input  logic [NUM_WR*DATA_W-1:0]    wr_value,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
  output logic [DATA_W-1:0]           next_data,
  output logic                        next_ready,
  output logic                        hit_dup,
  output logic                        hit_alloc
);
  localparam logic [IDX_W-1:0] ME = IDX_W'(IDX);
  logic wr_hit;
  logic al_hit;
  always_comb begin
    next_data = cur_data;
    wr_hit = 1'b0;
    hit_dup = 1'b0;
    al_hit = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (wr_en[p] && wr_idx[p*IDX_W +: IDX_W] == ME) begin
        hit_dup = hit_dup | wr_hit;
        wr_hit = 1'b1;
        next_data = wr_value[p*DATA_W +: DATA_W];
      end
    end
    for (int a = 0; a < NUM_ALLOC; a++)
      al_hit = al_hit | (alloc_en[a] && alloc_idx[a*IDX_W +: IDX_W] == ME);
    next_ready = al_hit ? 1'b0 : (wr_hit ? 1'b1 : cur_ready);
    hit_alloc = al_hit & wr_hit;
  end
endmodule

// File: rtl/prf_sb_bypass.sv
// prf_sb_bypass: parametrised PRF with ready scoreboard, optional write-to-read bypass, and registered err_wr_dup/err_wr_alloc conflict pulses
module prf_sb_bypass
  import prf_pkg::*;
#(
  parameter int NUM_PREGS = PRF_NUM_PREGS,
  parameter int DATA_W = PRF_DATA_W,
  parameter int NUM_RD = 12,
  parameter int NUM_WR = 6,
  parameter int NUM_ALLOC = 2,
  parameter int BYPASS = 1,
  parameter int IDX_W = PRF_IDX_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_RD*IDX_W-1:0]     rd_idx,
  output logic [NUM_RD*DATA_W-1:0]    rd_value,
  output logic [NUM_RD-1:0]           rd_ready,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*IDX_W-1:0]     wr_idx,
  input  logic [NUM_WR*DATA_W-1:0]    wr_value,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*IDX_W-1:0]  alloc_idx,
  output logic                        err_wr_dup,
  output logic                        err_wr_alloc
);
  if (IDX_W < clog2(NUM_PREGS)) begin : g_idx_chk
    $error("prf_sb_bypass: IDX_W too small for NUM_PREGS");
  end
  logic [DATA_W-1:0] data [NUM_PREGS];
  logic [DATA_W-1:0] nd [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready, nr, hd, ha;
  for (genvar e = 0; e < NUM_PREGS; e++) begin : g_ent
    prf_wr_merge #(
      .IDX(e), .NUM_WR(NUM_WR), .NUM_ALLOC(NUM_ALLOC), .DATA_W(DATA_W), .IDX_W(IDX_W)
    ) u_merge (
      .cur_data(data[e]),
      .cur_ready(ready[e]),
      .wr_en(wr_en),
      .wr_idx(wr_idx),
      .wr_value(wr_value),
      .alloc_en(alloc_en),
      .alloc_idx(alloc_idx),
      .next_data(nd[e]),
      .next_ready(nr[e]),
      .hit_dup(hd[e]),
      .hit_alloc(ha[e])
    );
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < NUM_PREGS; e++) data[e] <= '0;
      ready <= '1;
      err_wr_dup <= 1'b0;
      err_wr_alloc <= 1'b0;
    end else begin
      for (int e = 0; e < NUM_PREGS; e++) data[e] <= nd[e];
      ready <= nr;
      err_wr_dup <= |hd;
      err_wr_alloc <= |ha;
    end
  end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [IDX_W-1:0] idx;
    logic in_r;
    logic [DATA_W-1:0] v;
    logic r;
    assign idx = rd_idx[k*IDX_W +: IDX_W];
    assign in_r = {1'b0, idx} < (IDX_W+1)'(NUM_PREGS);
    always_comb begin
      v = in_r ? data[idx] : '0;
      r = in_r & ready[idx];
      for (int p = 0; p < NUM_WR; p++) begin
        if (BYPASS != 0 && in_r && wr_en[p] && wr_idx[p*IDX_W +: IDX_W] == idx) begin
          v = wr_value[p*DATA_W +: DATA_W];
          r = 1'b1;
        end
      end
    end
    assign rd_value[k*DATA_W +: DATA_W] = v;
    assign rd_ready[k] = r;
  end
endmodule
